// File: rtl/dfe_pkg.sv
// Shared definitions for the hash-core datapath and its cache.
// Holds the hash-core state encoding, the default table geometry and
// the clog2 helper used for address widths on both sides of the port.
package dfe_pkg;

    // Hash-core sequencing states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        CMP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Default table geometry (a core instance may override BIT_ON_TAILS)
    localparam int DEFAULT_BIT_ON_TAILS = 7;
    localparam int HASH_LEN             = 1 << DEFAULT_BIT_ON_TAILS;
    localparam int MASK                 = HASH_LEN - 1;
    localparam int HASH_ADDR_W          = DEFAULT_BIT_ON_TAILS + 1;

    // Ceiling log2 for elaboration-time width calculations; clog2(1) == 0
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage : dfe_pkg

// File: rtl/hash_probe_unit.sv
// Combinational slot decision for one linear-probing step.
// Given the word being inserted and the slot contents returned by the cache,
// reports whether the slot is empty, already holds the word, or whether the
// whole table has been walked without finding room. Also supplies the next
// slot in probe order (wrapping at the top of the table) and the
// incremented, saturating occurrence count.
module hash_probe_unit
    import dfe_pkg::*;
#(
    parameter int DATA_INDEX_WIDTH = 32,
    parameter int BIT_ON_TAILS     = DEFAULT_BIT_ON_TAILS
) (
    input  logic [DATA_INDEX_WIDTH-1:0] dataR,
    input  logic [DATA_INDEX_WIDTH-1:0] hashValue,
    input  logic [DATA_INDEX_WIDTH-1:0] occurrValue,
    input  logic [BIT_ON_TAILS-1:0]     probe,
    input  logic [BIT_ON_TAILS-1:0]     slot,
    output logic                        empty,
    output logic                        match,
    output logic                        full,
    output logic [BIT_ON_TAILS-1:0]     nextSlot,
    output logic [DATA_INDEX_WIDTH-1:0] satCount
);

    // Slot classification and next-probe arithmetic
    // NOTE: every output gets a value on every path so no latch is inferred.
    always_comb begin
        empty    = (occurrValue == '0);
        match    = !empty && (hashValue == dataR);
        // Last probe position reached and still colliding: nowhere left to go
        full     = !empty && !match && (probe == {BIT_ON_TAILS{1'b1}});
        // Natural modulo wrap: the top slot rolls over to slot 0
        nextSlot = slot + BIT_ON_TAILS'(1);
        // Count sticks at all-ones instead of wrapping back to "empty"
        satCount = (&occurrValue) ? occurrValue
                                  : occurrValue + DATA_INDEX_WIDTH'(1);
    end

endmodule : hash_probe_unit

// File: rtl/hash_core.sv
// Frequency-counting engine sitting beside the cache on its hash-core port.
// Walks the data stream 0..LENGTH_ARRAY-1 and inserts each word into an
// open-addressed (linear probing) table of {value, count} slots held in the
// cache, keyed by the low BIT_ON_TAILS bits of the word. A zero count marks
// an empty slot. Words that find no room after a full table walk are counted
// in drop_count. cache_busy stalls the engine without consuming stale reads.
//
// Build option: define HASH_CORE_MAX_TRACK_EN to add max_value/max_count,
// the most frequent value written during the current pass.
module hash_core
    import dfe_pkg::*;
#(
    parameter int LENGTH_ARRAY     = 100,
    parameter int DATA_INDEX_WIDTH = 32,
    parameter int BIT_ON_TAILS     = DEFAULT_BIT_ON_TAILS,
    localparam int indexW = (clog2(LENGTH_ARRAY) > 0) ? clog2(LENGTH_ARRAY) : 1,
    localparam int dropW  = clog2(LENGTH_ARRAY + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        cache_busy,
    output logic                        busy,
    output logic                        done,
    output logic [indexW-1:0]           index,
    input  logic [DATA_INDEX_WIDTH-1:0] data_stream,
    output logic [BIT_ON_TAILS:0]       hash_occurr_addr,
    input  logic [DATA_INDEX_WIDTH-1:0] hash_value,
    input  logic [DATA_INDEX_WIDTH-1:0] occurr_value,
    output logic                        wr_en,
    output logic [DATA_INDEX_WIDTH-1:0] new_hash_value,
    output logic [DATA_INDEX_WIDTH-1:0] new_occurr_value,
    output logic [dropW-1:0]            drop_count
`ifdef HASH_CORE_MAX_TRACK_EN
    ,
    output logic [DATA_INDEX_WIDTH-1:0] max_value,
    output logic [DATA_INDEX_WIDTH-1:0] max_count
`endif
);

    state_t                      state;
    state_t                      nextState;
    logic [DATA_INDEX_WIDTH-1:0] dataR;
    logic [BIT_ON_TAILS-1:0]     slot;
    logic [BIT_ON_TAILS-1:0]     probe;

    logic                        empty;
    logic                        match;
    logic                        full;
    logic [BIT_ON_TAILS-1:0]     nextSlot;
    logic [DATA_INDEX_WIDTH-1:0] satCount;

    logic                        resolved;
    logic                        lastIndex;

    hash_probe_unit #(
        .DATA_INDEX_WIDTH (DATA_INDEX_WIDTH),
        .BIT_ON_TAILS     (BIT_ON_TAILS)
    ) u_probe (
        .dataR       (dataR),
        .hashValue   (hash_value),
        .occurrValue (occurr_value),
        .probe       (probe),
        .slot        (slot),
        .empty       (empty),
        .match       (match),
        .full        (full),
        .nextSlot    (nextSlot),
        .satCount    (satCount)
    );

    // The current element is finished (written or dropped) in this CMP
    assign resolved  = empty || match || full;
    assign lastIndex = (index == indexW'(LENGTH_ARRAY - 1));

    // State register
    // NOTE: reset is sampled on the clock edge only (synchronous), so it
    // belongs inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register updates from pre-edge values regardless of block order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decision, including stalls from the cache port
    always_comb begin
        nextState = state;
        case (state)
            IDLE:  if (start) nextState = FETCH;
            FETCH: if (!cache_busy) nextState = WAIT;
            // The cache latches the slot on the edge leaving WAIT
            WAIT:  if (!cache_busy) nextState = CMP;
            CMP: begin
                if (cache_busy) begin
                    // Slot data may be stale: re-issue the read
                    nextState = WAIT;
                end else if (resolved) begin
                    nextState = lastIndex ? DONE : FETCH;
                end else begin
                    nextState = WAIT;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Slot address, write strobe/data and done pulse
    always_comb begin
        hash_occurr_addr = {1'b0, slot};
        wr_en            = 1'b0;
        new_hash_value   = '0;
        new_occurr_value = '0;
        done             = (state == DONE);
        if ((state == CMP) && !cache_busy && (empty || match)) begin
            wr_en            = 1'b1;
            new_hash_value   = dataR;
            new_occurr_value = empty ? DATA_INDEX_WIDTH'(1) : satCount;
        end
    end

    // Stream position, probe cursor, drop counter and busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            index      <= '0;
            drop_count <= '0;
            dataR      <= '0;
            slot       <= '0;
            probe      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        index      <= '0;
                        drop_count <= '0;
                        busy       <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!cache_busy) begin
                        dataR <= data_stream;
                        slot  <= data_stream[BIT_ON_TAILS-1:0];
                        probe <= '0;
                    end
                end
                CMP: begin
                    if (!cache_busy) begin
                        if (resolved) begin
                            if (full) begin
                                drop_count <= drop_count + dropW'(1);
                            end
                            if (!lastIndex) begin
                                index <= index + indexW'(1);
                            end
                        end else begin
                            slot  <= nextSlot;
                            probe <= probe + BIT_ON_TAILS'(1);
                        end
                    end
                end
                DONE:    busy <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef HASH_CORE_MAX_TRACK_EN
    // Most frequent value written this pass; ties keep the earlier value
    always_ff @(posedge clk) begin
        if (rst) begin
            max_value <= '0;
            max_count <= '0;
        end else if ((state == IDLE) && start) begin
            max_value <= '0;
            max_count <= '0;
        end else if (wr_en && (new_occurr_value > max_count)) begin
            max_value <= new_hash_value;
            max_count <= new_occurr_value;
        end
    end
`endif

endmodule : hash_core

// File: tb/tb_hash_core.sv
// Self-checking bench for hash_core with a small 4-slot table.
// The bench plays the cache: it serves the data stream, holds the slot table,
// registers slot reads one cycle after the address and returns garbage while
// cache_busy is high. Expected tables, drop counts, pass lengths and maxima
// come from a straightforward insertion model over plain arrays.
module tb_hash_core;

    localparam int LA = 5;
    localparam int DW = 32;
    localparam int BT = 2;
    localparam int HL = 1 << BT;
    localparam logic [DW-1:0] ALL_ONES = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          cache_busy;
    logic          busy;
    logic          done;
    logic [2:0]    index;
    logic [DW-1:0] data_stream;
    logic [BT:0]   hash_occurr_addr;
    logic [DW-1:0] hash_value;
    logic [DW-1:0] occurr_value;
    logic          wr_en;
    logic [DW-1:0] new_hash_value;
    logic [DW-1:0] new_occurr_value;
    logic [2:0]    drop_count;
`ifdef HASH_CORE_MAX_TRACK_EN
    logic [DW-1:0] max_value;
    logic [DW-1:0] max_count;
`endif

    hash_core #(
        .LENGTH_ARRAY     (LA),
        .DATA_INDEX_WIDTH (DW),
        .BIT_ON_TAILS     (BT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .cache_busy       (cache_busy),
        .busy             (busy),
        .done             (done),
        .index            (index),
        .data_stream      (data_stream),
        .hash_occurr_addr (hash_occurr_addr),
        .hash_value       (hash_value),
        .occurr_value     (occurr_value),
        .wr_en            (wr_en),
        .new_hash_value   (new_hash_value),
        .new_occurr_value (new_occurr_value),
        .drop_count       (drop_count)
`ifdef HASH_CORE_MAX_TRACK_EN
        ,
        .max_value        (max_value),
        .max_count        (max_count)
`endif
    );

    always #5 clk = ~clk;

    // Cache model storage and data stream
    logic [DW-1:0] memVal [HL];
    logic [DW-1:0] memCnt [HL];
    logic [DW-1:0] stream [LA];

    assign data_stream = (int'(index) < LA) ? stream[index] : '0;

    // Monitors (monotonic; passes take differences)
    int wrCount   = 0;
    int badWrites = 0;
    int addrErr   = 0;
    int doneCount = 0;

    // Cache read/write port: writes land on the edge, reads are registered
    always @(posedge clk) begin
        if (wr_en) begin
            memVal[hash_occurr_addr[BT-1:0]] <= new_hash_value;
            memCnt[hash_occurr_addr[BT-1:0]] <= new_occurr_value;
        end
        if (cache_busy) begin
            hash_value   <= $urandom;
            occurr_value <= $urandom;
        end else begin
            hash_value   <= memVal[hash_occurr_addr[BT-1:0]];
            occurr_value <= memCnt[hash_occurr_addr[BT-1:0]];
        end
        wrCount   <= wrCount + (wr_en ? 1 : 0);
        badWrites <= badWrites + ((wr_en && cache_busy) ? 1 : 0);
        addrErr   <= addrErr + ((hash_occurr_addr[BT] !== 1'b0) ? 1 : 0);
        doneCount <= doneCount + ((done === 1'b1) ? 1 : 0);
    end

    int nAsserts = 0;
    int nFails   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model results
    logic [DW-1:0] refVal [HL];
    logic [DW-1:0] refCnt [HL];
    int            refDrop;
    int            refExtra;
    logic [DW-1:0] refMaxV;
    logic [DW-1:0] refMaxC;

    // Insert every stream word into a copy of the current table
    task automatic modelPass();
        for (int k = 0; k < HL; k++) begin
            refVal[k] = memVal[k];
            refCnt[k] = memCnt[k];
        end
        refDrop  = 0;
        refExtra = 0;
        refMaxV  = '0;
        refMaxC  = '0;
        for (int e = 0; e < LA; e++) begin
            logic [DW-1:0] w;
            logic [DW-1:0] newCnt;
            bit            placed;
            int            home;
            w      = stream[e];
            home   = int'(w % HL);
            placed = 1'b0;
            newCnt = '0;
            for (int p = 0; p < HL && !placed; p++) begin
                int k;
                k = (home + p) % HL;
                if (refCnt[k] == 0) begin
                    refVal[k] = w;
                    refCnt[k] = 1;
                    newCnt    = 1;
                    placed    = 1'b1;
                    refExtra += 2 * p;
                end else if (refVal[k] == w) begin
                    if (refCnt[k] != ALL_ONES) refCnt[k] = refCnt[k] + 1;
                    newCnt    = refCnt[k];
                    placed    = 1'b1;
                    refExtra += 2 * p;
                end
            end
            if (!placed) begin
                refDrop++;
                refExtra += 2 * (HL - 1);
            end else if (newCnt > refMaxC) begin
                refMaxC = newCnt;
                refMaxV = w;
            end
        end
    endtask

    task automatic clearTable();
        for (int k = 0; k < HL; k++) begin
            memVal[k] = '0;
            memCnt[k] = '0;
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_index"}, index, 0);
        check({tag, "_addr"}, hash_occurr_addr, 0);
        check({tag, "_drop"}, drop_count, 0);
        check({tag, "_new_hash"}, new_hash_value, 0);
        check({tag, "_new_occurr"}, new_occurr_value, 0);
    endtask

    // stallMode: 0 none (plus an ignored re-start), 1 random, 2 one 4-cycle stall in CMP
    task automatic runPass(input int stallMode, input int rstAt, input string tag);
        int cyc;
        int stallLeft;
        int w0;
        int b0;
        int a0;
        int d0;
        bit seenDone;
        bit aborted;
        bit stallDone;
        modelPass();
        w0 = wrCount;
        b0 = badWrites;
        a0 = addrErr;
        d0 = doneCount;
        cyc       = 0;
        stallLeft = 0;
        seenDone  = 1'b0;
        aborted   = 1'b0;
        stallDone = 1'b0;
        @(negedge clk);
        start = 1'b1;
        while (!seenDone && !aborted && cyc < 400) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (stallMode == 0 && cyc == 5) start = 1'b1;
            if (rstAt > 0 && cyc == rstAt) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checkIdleOutputs({tag, "_abort"});
                aborted = 1'b1;
            end else if (done) begin
                seenDone = 1'b1;
            end else if (stallMode == 1) begin
                cache_busy = ($urandom_range(0, 3) == 0);
            end else if (stallMode == 2) begin
                if (stallLeft > 0) begin
                    check({tag, "_stall_wr_en"}, wr_en, 0);
                    stallLeft--;
                    if (stallLeft == 0) cache_busy = 1'b0;
                end else if (!stallDone && wr_en) begin
                    cache_busy = 1'b1;
                    stallLeft  = 4;
                    stallDone  = 1'b1;
                    #1;
                    check({tag, "_stall_suppress"}, wr_en, 0);
                end
            end
        end
        cache_busy = 1'b0;
        if (aborted) begin
            repeat (20) @(negedge clk);
            check({tag, "_no_done_after_abort"}, doneCount - d0, 0);
            check({tag, "_idle_after_abort"}, busy, 0);
            return;
        end
        check({tag, "_done_seen"}, seenDone, 1);
        if (stallMode == 0) check({tag, "_cycles"}, cyc, 3 * LA + 1 + refExtra);
        if (stallMode == 2) check({tag, "_stall_applied"}, stallDone, 1);
        check({tag, "_drop_count"}, drop_count, refDrop);
`ifdef HASH_CORE_MAX_TRACK_EN
        check({tag, "_max_value"}, max_value, refMaxV);
        check({tag, "_max_count"}, max_count, refMaxC);
`endif
        @(negedge clk);
        check({tag, "_done_width"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_done_pulses"}, doneCount - d0, 1);
        check({tag, "_writes"}, wrCount - w0, LA - refDrop);
        check({tag, "_busy_writes"}, badWrites - b0, 0);
        check({tag, "_addr_msb"}, addrErr - a0, 0);
        for (int k = 0; k < HL; k++) begin
            check($sformatf("%s_slot%0d_value", tag, k), memVal[k], refVal[k]);
            check($sformatf("%s_slot%0d_count", tag, k), memCnt[k], refCnt[k]);
        end
    endtask

    task automatic setStream(input int a, input int b, input int c, input int d, input int e);
        stream[0] = DW'(a);
        stream[1] = DW'(b);
        stream[2] = DW'(c);
        stream[3] = DW'(d);
        stream[4] = DW'(e);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cache_busy = 1'b0;
        clearTable();
        setStream(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
`ifdef HASH_CORE_MAX_TRACK_EN
        check("reset_max_value", max_value, 0);
        check("reset_max_count", max_count, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Repeated word then a colliding word
        clearTable();
        setStream(5, 5, 5, 9, 9);
        runPass(0, 0, "repeat");
        check("repeat_slot1_direct", memCnt[1], 3);

        // Four words fill the table; the fifth wraps 3->0 and is dropped
        clearTable();
        setStream(1, 5, 9, 13, 17);
        runPass(0, 0, "full");
        check("full_drop_direct", drop_count, 1);

        // Saturated count stays at all-ones
        clearTable();
        memVal[1] = 5;
        memCnt[1] = ALL_ONES;
        setStream(5, 5, 5, 5, 5);
        runPass(0, 0, "saturate");
        check("saturate_direct", memCnt[1], ALL_ONES);

        // Stall in CMP; result must match the unstalled model
        clearTable();
        setStream(7, 3, 3, 7, 3);
        runPass(2, 0, "stall");
`ifdef HASH_CORE_MAX_TRACK_EN
        check("stall_max_value_direct", max_value, 3);
        check("stall_max_count_direct", max_count, 3);
`endif

        // Reset mid-pass, then a fresh complete pass
        clearTable();
        setStream(2, 6, 10, 3, 2);
        runPass(0, 8, "abort");
        clearTable();
        runPass(0, 0, "after_abort");

        // Randomized passes; the table carries over between some of them
        for (int t = 0; t < 10; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                clearTable();
                for (int k = 0; k < HL; k++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        memVal[k] = DW'($urandom_range(0, 11));
                        memCnt[k] = ($urandom_range(0, 1) == 0) ? (ALL_ONES - 1) : DW'($urandom_range(1, 5));
                    end
                end
            end
            for (int i = 0; i < LA; i++) begin
                stream[i] = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 11));
            end
            runPass(int'($urandom_range(0, 1)), 0, $sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_hash_core
